cache_ctrl_param: RTL and testbench

Parametrised successor of the two-way cache controller FSM.
- Sits between the CPU-side request (Rd/Wr) and the banked main memory; drives the cache array and the victim-way logic.
- Line length (WORDS) and memory read latency (MEM_LAT) are parameters.
- Fill and writeback sequencing is done by word counters, not unrolled states.
- The CPU operation is latched at acceptance, so a miss completes correctly even if Rd/Wr change mid-miss.

---
 rtl/cache_ctrl_pkg.sv | 27 ++
 rtl/cache_ctrl_word_cnt.sv | 45 ++++
 rtl/cache_ctrl_param.sv | 271 +++++++++++++++++++++++++++
 tb/tb_cache_ctrl_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the parametrised two-way cache controller.
// Holds the controller state encoding, the largest supported line length and
// the word-index to byte-offset conversion used by both counters.
package cache_ctrl_pkg;

    // Largest supported line length in 16-bit words.
    localparam int MAX_WORDS = 16;
    localparam int MAX_IDX_W = $clog2(MAX_WORDS);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        COMPARE   = 4'd1,
        WB        = 4'd2,
        ALLOC     = 4'd3,
        DRAIN     = 4'd4,
        ALLOC_WR  = 4'd5,
        HIT_DONE  = 4'd6,
        MISS_DONE = 4'd7,
        ERR       = 4'd8
    } state_e;

    // Words are 16 bits wide, so the byte offset is the word index shifted by one.
    function automatic logic [MAX_IDX_W:0] word_to_off(input logic [MAX_IDX_W-1:0] idx);
        return {idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_ctrl_word_cnt.sv
// Word counter for line sequencing: clear, increment-enable, terminal count at WORDS-1.
// Latency: count updates on the clock after clr/inc; tc is combinational from the count.
// Backpressure: the caller gates inc (e.g. with mem_stall); the count holds otherwise.
// Ports: clk, rst (async, active-high), clr, inc -> cnt[$clog2(WORDS)-1:0], tc.
module cache_ctrl_word_cnt
    import cache_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       inc,
    output logic [$clog2(WORDS)-1:0]   cnt,
    output logic                       tc
);

    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // WORDS is a power of two, so the increment past LAST wraps to 0 by itself.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/cache_ctrl_param.sv
// Two-way cache controller FSM with parametrised line length and memory read latency.
// Latency: hit 2 cycles; clean miss 1+WORDS+MEM_LAT+1; dirty miss +WORDS; write miss +1; +1 per stall.
// Backpressure: mem_stall holds the writeback/issue and fill counters; CPU sees stall_out until done.
// Ports: clk, rst (async, active-high); CPU Rd/Wr; cache status hit/valid/dirty; mem_stall;
//   cache controls comp, cache_write, cache_offset(_select), cache_data_in_select, tag_select,
//   valid_in, enable, flip_victimway; memory mem_rd/mem_wr/mem_offset; cache_hit, stall_out, done, err.
// Optional: define CACHE_CTRL_PERF_EN to add saturating hit_cnt, miss_cnt, wb_cnt_total outputs.
module cache_ctrl_param
    import cache_ctrl_pkg::*;
#(
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    parameter int OFF_W   = $clog2(WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Rd,
    input  logic             Wr,
    input  logic             hit,
    input  logic             valid,
    input  logic             dirty,
    input  logic             mem_stall,
    output logic             comp,
    output logic             cache_write,
    output logic [OFF_W-1:0] cache_offset,
    output logic             cache_offset_select,
    output logic             cache_data_in_select,
    output logic             tag_select,
    output logic [OFF_W-1:0] mem_offset,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             valid_in,
    output logic             enable,
    output logic             flip_victimway,
    output logic             cache_hit,
    output logic             stall_out,
    output logic             done,
    output logic             err
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt,
    output logic [15:0]      wb_cnt_total
`endif
);

    localparam int CW = $clog2(WORDS);
    localparam logic [CW:0] LAT_W = MEM_LAT[CW:0];

    state_e state_q;
    state_e state_d;
    logic   op_wr_q;
    logic   op_wr_d;

    logic [CW-1:0]    iss_cnt;
    logic [CW-1:0]    fill_cnt;
    logic             iss_tc;
    logic             fill_tc;
    logic             cnt_clr;
    logic             iss_inc;
    logic             fill_inc;
    logic             fill_now;
    logic [OFF_W-1:0] iss_off;
    logic [OFF_W-1:0] fill_off;

    // The writeback and issue phases never overlap, so they share one counter.
    // Both counters are held at zero outside the line-transfer states.
    assign cnt_clr  = !(state_q == WB || state_q == ALLOC || state_q == DRAIN);
    // Data for word N arrives MEM_LAT accepted issues later, so filling starts once
    // the issue counter has run MEM_LAT words ahead; fill_cnt then tracks iss_cnt-MEM_LAT.
    assign fill_now = ({1'b0, iss_cnt} >= LAT_W);
    assign iss_inc  = (state_q == WB || state_q == ALLOC) && !mem_stall;
    // Memory data already in flight keeps arriving in DRAIN, so stalls do not apply there.
    assign fill_inc = (state_q == ALLOC && fill_now && !mem_stall) || (state_q == DRAIN);

    assign iss_off  = OFF_W'(word_to_off(MAX_IDX_W'(iss_cnt)));
    assign fill_off = OFF_W'(word_to_off(MAX_IDX_W'(fill_cnt)));

    cache_ctrl_word_cnt #(.WORDS(WORDS)) u_iss_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (iss_inc),
        .cnt (iss_cnt),
        .tc  (iss_tc)
    );

    cache_ctrl_word_cnt #(.WORDS(WORDS)) u_fill_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (fill_inc),
        .cnt (fill_cnt),
        .tc  (fill_tc)
    );

    // Next state; the CPU operation is captured at acceptance so later Rd/Wr changes
    // cannot alter an in-flight miss.
    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        case (state_q)
            IDLE, HIT_DONE, MISS_DONE: begin
                if (Rd && Wr) begin
                    state_d = ERR;
                end else if (Rd ^ Wr) begin
                    state_d = COMPARE;
                    op_wr_d = Wr;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                if (hit && valid) begin
                    state_d = HIT_DONE;
                end else if (dirty) begin
                    state_d = WB;
                end else begin
                    state_d = ALLOC;
                end
            end
            WB: begin
                if (!mem_stall && iss_tc) begin
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                if (!mem_stall && iss_tc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fill_tc) begin
                    state_d = op_wr_q ? ALLOC_WR : MISS_DONE;
                end
            end
            ALLOC_WR: state_d = MISS_DONE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
        end
    end

    // Outputs are decoded from state and counters only, never from the current inputs.
    always_comb begin
        comp                 = 1'b0;
        cache_write          = 1'b0;
        cache_offset         = '0;
        cache_offset_select  = 1'b0;
        cache_data_in_select = 1'b0;
        tag_select           = 1'b0;
        mem_offset           = '0;
        mem_rd               = 1'b0;
        mem_wr               = 1'b0;
        valid_in             = 1'b0;
        enable               = 1'b0;
        flip_victimway       = 1'b0;
        cache_hit            = 1'b0;
        stall_out            = 1'b1;
        done                 = 1'b0;
        err                  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_out = 1'b0;
                enable    = 1'b1;
            end
            COMPARE: begin
                comp           = 1'b1;
                cache_write    = op_wr_q;
                enable         = 1'b1;
                flip_victimway = 1'b1;
            end
            WB: begin
                mem_wr              = 1'b1;
                tag_select          = 1'b1;
                cache_offset_select = 1'b1;
                cache_offset        = iss_off;
                mem_offset          = iss_off;
            end
            ALLOC: begin
                mem_rd     = 1'b1;
                mem_offset = iss_off;
                // While stalled this write repeats with the same word and data.
                if (fill_now) begin
                    cache_write          = 1'b1;
                    valid_in             = 1'b1;
                    cache_offset_select  = 1'b1;
                    cache_data_in_select = 1'b1;
                    cache_offset         = fill_off;
                end
            end
            DRAIN: begin
                cache_write          = 1'b1;
                valid_in             = 1'b1;
                cache_offset_select  = 1'b1;
                cache_data_in_select = 1'b1;
                cache_offset         = fill_off;
            end
            ALLOC_WR: begin
                // CPU word written into the freshly filled line, which marks it dirty.
                comp        = 1'b1;
                cache_write = 1'b1;
                valid_in    = 1'b1;
            end
            HIT_DONE: begin
                done      = 1'b1;
                cache_hit = 1'b1;
                stall_out = 1'b0;
            end
            MISS_DONE: begin
                done      = 1'b1;
                stall_out = 1'b0;
            end
            ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] hit_cnt_d;
    logic [15:0] miss_cnt_q;
    logic [15:0] miss_cnt_d;
    logic [15:0] wb_tot_q;
    logic [15:0] wb_tot_d;

    // Counted on state entry; all three saturate rather than wrap.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_tot_d   = wb_tot_q;
        if (state_d == HIT_DONE && state_q != HIT_DONE && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (state_d == MISS_DONE && state_q != MISS_DONE && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
        if (state_d == WB && state_q != WB && wb_tot_q != 16'hFFFF) begin
            wb_tot_d = wb_tot_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_tot_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_tot_q   <= wb_tot_d;
        end
    end

    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign wb_cnt_total = wb_tot_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Bench for cache_ctrl_param: directed and random CPU operations against a
// transaction-level model (expected latency, writeback/read/fill word order,
// memory-latency spacing of fills, hit flag), with a stalling memory responder.
module tb_cache_ctrl_param;

    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int OFF_W   = $clog2(WORDS) + 1;

    logic clk = 1'b0;
    logic rst;
    logic Rd, Wr, hit, valid, dirty, mem_stall;
    logic comp, cache_write, cache_offset_select, cache_data_in_select, tag_select;
    logic [OFF_W-1:0] cache_offset, mem_offset;
    logic mem_rd, mem_wr, valid_in, enable, flip_victimway, cache_hit, stall_out, done, err;
`ifdef CACHE_CTRL_PERF_EN
    logic [15:0] hit_cnt, miss_cnt, wb_cnt_total;
    int m_hits = 0, m_miss = 0, m_wb = 0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_ctrl_param #(.WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .Rd                   (Rd),
        .Wr                   (Wr),
        .hit                  (hit),
        .valid                (valid),
        .dirty                (dirty),
        .mem_stall            (mem_stall),
        .comp                 (comp),
        .cache_write          (cache_write),
        .cache_offset         (cache_offset),
        .cache_offset_select  (cache_offset_select),
        .cache_data_in_select (cache_data_in_select),
        .tag_select           (tag_select),
        .mem_offset           (mem_offset),
        .mem_rd               (mem_rd),
        .mem_wr               (mem_wr),
        .valid_in             (valid_in),
        .enable               (enable),
        .flip_victimway       (flip_victimway),
        .cache_hit            (cache_hit),
        .stall_out            (stall_out),
        .done                 (done),
        .err                  (err)
`ifdef CACHE_CTRL_PERF_EN
        ,
        .hit_cnt              (hit_cnt),
        .miss_cnt             (miss_cnt),
        .wb_cnt_total         (wb_cnt_total)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef CACHE_CTRL_PERF_EN
        check({tag, ":hit_cnt"},  32'(hit_cnt),      32'(m_hits));
        check({tag, ":miss_cnt"}, 32'(miss_cnt),     32'(m_miss));
        check({tag, ":wb_total"}, 32'(wb_cnt_total), 32'(m_wb));
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, ":stall_out"}, 32'(stall_out), 32'd1 - 32'd1);
        check({tag, ":enable"},    32'(enable),    32'd1);
        check({tag, ":busy"},      32'({mem_rd, mem_wr, cache_write, comp, done, err}), 32'd0);
    endtask

    // One CPU operation from IDLE. The memory responder stalls the transfer with
    // index stall_at (writebacks first, then reads) for stall_len cycles.
    task automatic run_txn(input string name, input bit op_wr, input bit h, input bit v,
                           input bit d, input int stall_at, input int stall_len);
        int  exp_lat, nx, xfer, stalls_done, stalls_total, done_cyc, exp_off, n_words;
        bit  is_hit, saw_awr, got_hit;
        int  wb_offs[$];
        int  rd_offs[$];
        int  rd_cyc[$];
        int  fill_offs[$];
        int  fill_cyc[$];

        is_hit       = h & v;
        n_words      = is_hit ? 0 : WORDS;
        nx           = is_hit ? 0 : (d ? 2 * WORDS : WORDS);
        stalls_total = (stall_at < nx) ? stall_len : 0;
        exp_lat      = is_hit ? 2
                     : 1 + (d ? WORDS : 0) + WORDS + MEM_LAT + (op_wr ? 1 : 0) + stalls_total + 1;

        @(negedge clk);
        Rd = !op_wr; Wr = op_wr; hit = h; valid = v; dirty = d; mem_stall = 1'b0;
        done_cyc = -1; xfer = 0; stalls_done = 0; saw_awr = 1'b0; got_hit = 1'b0;

        for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check({name, ":cmp_comp"},  32'(comp),           32'd1);
                check({name, ":cmp_flip"},  32'(flip_victimway), 32'd1);
                check({name, ":cmp_wr"},    32'(cache_write),    32'(op_wr));
                check({name, ":cmp_stall"}, 32'(stall_out),      32'd1);
            end
            // CPU inputs wander mid-miss; the controller must rely on its latched op.
            if (c >= 2 && c <= exp_lat - 2) begin
                Rd = 1'($urandom); Wr = 1'($urandom);
                hit = 1'($urandom); valid = 1'($urandom); dirty = 1'($urandom);
            end else begin
                Rd = 1'b0; Wr = 1'b0;
            end
            // Memory responder.
            if (mem_rd || mem_wr) begin
                exp_off = mem_wr ? 2 * wb_offs.size() : 2 * rd_offs.size();
                check({name, ":mem_off"}, 32'(mem_offset), 32'(exp_off));
                if (mem_wr) begin
                    check({name, ":wb_tag"},  32'(tag_select),   32'd1);
                    check({name, ":wb_coff"}, 32'(cache_offset), 32'(exp_off));
                end
                if (xfer == stall_at && stalls_done < stall_len) begin
                    mem_stall = 1'b1;
                    stalls_done++;
                end else begin
                    mem_stall = 1'b0;
                    xfer++;
                    if (mem_wr) begin
                        wb_offs.push_back(int'(mem_offset));
                    end else begin
                        rd_offs.push_back(int'(mem_offset));
                        rd_cyc.push_back(c);
                    end
                end
            end else begin
                mem_stall = 1'($urandom);
            end
            if (cache_write && cache_data_in_select) begin
                check({name, ":fill_vin"}, 32'({valid_in, cache_offset_select}), 32'd3);
                if (fill_offs.size() == 0 || fill_offs[fill_offs.size()-1] != int'(cache_offset)) begin
                    fill_offs.push_back(int'(cache_offset));
                    fill_cyc.push_back(c);
                end
            end
            if (c > 1 && comp && cache_write && valid_in && !cache_offset_select && !cache_data_in_select)
                saw_awr = 1'b1;
            if (done) begin
                done_cyc = c;
                got_hit  = cache_hit;
                check({name, ":done_stall"}, 32'(stall_out), 32'd0);
            end
        end
        mem_stall = 1'b0;

        check({name, ":latency"},  32'(done_cyc),         32'(exp_lat));
        check({name, ":hit_flag"}, 32'(got_hit),          32'(is_hit));
        check({name, ":n_wb"},     32'(wb_offs.size()),   32'((!is_hit && d) ? WORDS : 0));
        check({name, ":n_rd"},     32'(rd_offs.size()),   32'(n_words));
        check({name, ":n_fill"},   32'(fill_offs.size()), 32'(n_words));
        check({name, ":alloc_wr"}, 32'(saw_awr),          32'(!is_hit && op_wr));
        for (int i = 0; i < fill_offs.size() && i < WORDS; i++)
            check({name, ":fill_off"}, 32'(fill_offs[i]), 32'(2 * i));
        if (stalls_total == 0) begin
            for (int i = 0; i < fill_cyc.size() && i < rd_cyc.size(); i++)
                check({name, ":fill_lat"}, 32'(fill_cyc[i] - rd_cyc[i]), 32'(MEM_LAT));
        end

`ifdef CACHE_CTRL_PERF_EN
        if (is_hit) m_hits++; else m_miss++;
        if (!is_hit && d) m_wb++;
`endif
        if (done_cyc < 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
`ifdef CACHE_CTRL_PERF_EN
            m_hits = 0; m_miss = 0; m_wb = 0;
`endif
        end else begin
            check_perf(name);
        end
    endtask

    initial begin
        rst = 1'b1; Rd = 1'b0; Wr = 1'b0; hit = 1'b0; valid = 1'b0; dirty = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check_perf("reset");

        // Directed operations: hit, clean read miss, dirty write miss, stalled issue.
        run_txn("rd_hit",     1'b0, 1'b1, 1'b1, 1'b0, 99, 0);
        run_txn("wr_hit",     1'b1, 1'b1, 1'b1, 1'b1, 99, 0);
        run_txn("rd_miss",    1'b0, 1'b0, 1'b0, 1'b0, 99, 0);
        run_txn("hit_invld",  1'b0, 1'b1, 1'b0, 1'b0, 99, 0);
        run_txn("wr_dirty",   1'b1, 1'b0, 1'b1, 1'b1, 99, 0);
        run_txn("stall_iss3", 1'b0, 1'b0, 1'b0, 1'b0, 2, 3);
        run_txn("stall_wb0",  1'b1, 1'b0, 1'b0, 1'b1, 0, 2);
        run_txn("stall_last", 1'b0, 1'b0, 1'b0, 1'b1, 2 * WORDS - 1, 1);

        // Back-to-back hits: a new request in HIT_DONE goes straight to COMPARE.
        @(negedge clk);
        Rd = 1'b1; hit = 1'b1; valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) Rd = 1'b0;
            check("b2b_done",  32'(done),      32'(c % 2 == 0));
            check("b2b_stall", 32'(stall_out), 32'(c % 2 != 0));
        end
`ifdef CACHE_CTRL_PERF_EN
        m_hits += 2;
`endif
        check_perf("b2b");

        // Rd and Wr together: one-cycle error pulse, then IDLE.
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b1;
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0;
        check("err_pulse", 32'(err),       32'd1);
        check("err_stall", 32'(stall_out), 32'd1);
        @(negedge clk);
        check("err_clear", 32'(err), 32'd0);
        check_idle("after_err");

        // Random operations with random single stall bursts.
        for (int i = 0; i < 40; i++) begin
            run_txn("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 2 * WORDS), $urandom_range(0, 3));
        end

        // Reset while draining: outputs fall back to IDLE at once.
        @(negedge clk);
        Rd = 1'b1; hit = 1'b0; valid = 1'b0; dirty = 1'b0;
        for (int c = 1; c <= 2 + WORDS; c++) begin
            @(negedge clk);
            Rd = 1'b0;
        end
        check("drain_fill", 32'({cache_write, cache_data_in_select, mem_rd}), 32'd6);
        #1 rst = 1'b1;
        #1 check_idle("rst_drain");
        @(negedge clk);
        rst = 1'b0;
`ifdef CACHE_CTRL_PERF_EN
        m_hits = 0; m_miss = 0; m_wb = 0;
`endif
        check_perf("rst_drain");
        run_txn("post_rst_hit", 1'b0, 1'b1, 1'b1, 1'b0, 99, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
